// File: rtl/button_gesture_decoder.sv
// Classifies a debounced button level into one-cycle gesture pulses:
// press, release, short click, long press and double click.
module button_gesture_decoder #(
    parameter int LONG_TICKS = 8,
    parameter int GAP_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       debounced_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_click,
    output logic       long_press,
    output logic       double_click,
    output logic [2:0] state
);

    localparam int MAX_TICKS = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(MAX_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESSED = 3'd1,
        S_LONG    = 3'd2,
        S_GAP     = 3'd3,
        S_SECOND  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_q;
    logic          rise, fall;
    logic          short_d, long_d, double_d;

    assign rise  = debounced_in & ~in_q;
    assign fall  = ~debounced_in & in_q;
    assign state = state_q;

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_PRESSED;
            end
            S_PRESSED: begin
                if (fall) begin
                    state_d = S_GAP;
                end else if (tick_en && cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = S_LONG;
                end
            end
            S_LONG: begin
                if (fall) state_d = S_IDLE;
            end
            S_GAP: begin
                if (rise) begin
                    state_d = S_SECOND;
                end else if (tick_en && cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SECOND: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (tick_en && cnt_q == LONG_LAST) begin
                    // The first click is already complete; the held second press turns long.
                    short_d = 1'b1;
                    long_d  = 1'b1;
                    state_d = S_LONG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter restarts on every state entry and saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (tick_en && cnt_q < CNT_TOP) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            in_q          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            in_q          <= debounced_in;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_click   <= short_d;
            long_press    <= long_d;
            double_click  <= double_d;
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder: expected pulses (edge number plus pulse
// vector) are queued as stimulus is driven and matched as the DUT raises pulses.
module tb_button_gesture_decoder;

    localparam logic [4:0] B_PRESS   = 5'b10000;
    localparam logic [4:0] B_RELEASE = 5'b01000;
    localparam logic [4:0] B_SHORT   = 5'b00100;
    localparam logic [4:0] B_LONG    = 5'b00010;
    localparam logic [4:0] B_DOUBLE  = 5'b00001;

    logic       clk;
    logic       rst;
    logic       tick_en;
    logic       debounced_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_click;
    logic       long_press;
    logic       double_click;
    logic [2:0] state;

    int n_tests;
    int n_fail;
    int cyc;
    int tick_mode;
    logic [20:0] exp_q[$];

    button_gesture_decoder #(.LONG_TICKS(8), .GAP_TICKS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .debounced_in (debounced_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_click  (short_click),
        .long_press   (long_press),
        .double_click (double_click),
        .state        (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic push(input int t, input logic [4:0] b);
        logic [15:0] tt;
        tt = t[15:0];
        exp_q.push_back({tt, b});
    endtask

    task automatic check_pulses();
        logic [4:0]  obs;
        logic [15:0] c16;
        logic [20:0] got;
        logic [20:0] want;
        obs = {press_pulse, release_pulse, short_click, long_press, double_click};
        if (obs != 5'b0) begin
            c16 = cyc[15:0];
            got = {c16, obs};
            if (exp_q.size() == 0) want = '0;
            else want = exp_q.pop_front();
            n_tests++;
            assert (got === want) else begin
                n_fail++;
                $error("FAIL pulse: observed edge %0d bits %b, expected edge %0d bits %b",
                       got[20:5], got[4:0], want[20:5], want[4:0]);
            end
        end
    endtask

    task automatic check_state(input logic [2:0] exp_s, input string tag);
        n_tests++;
        assert (state === exp_s) else begin
            n_fail++;
            $error("FAIL %s: observed state %0d, expected %0d", tag, state, exp_s);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            if (tick_mode == 0) tick_en = 1'b1;
            else if (tick_mode == 1) tick_en = ((cyc + 1) % 4 == 0);
            else tick_en = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_pulses();
        end
    endtask

    initial begin
        int p;
        int r;
        int h;
        logic [5:0] outs;
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        tick_mode    = 0;
        rst          = 1'b0;
        tick_en      = 1'b1;
        debounced_in = 1'b0;
        step(2);
        check_state(3'd0, "reset_state");
        outs = {press_pulse, release_pulse, short_click, long_press, double_click, 1'b0};
        n_tests++;
        assert (outs === 6'b0) else begin
            n_fail++;
            $error("FAIL reset_outs: observed %b, expected 000000", outs);
        end
        rst = 1'b1;
        step(2);

        // Short click
        debounced_in = 1'b1; p = cyc + 1; push(p, B_PRESS);
        step(3);
        check_state(3'd1, "t1_pressed");
        debounced_in = 1'b0; r = cyc + 1; push(r, B_RELEASE); push(r + 4, B_SHORT);
        step(2);
        check_state(3'd3, "t1_gap");
        step(8);
        check_state(3'd0, "t1_idle");

        // Long press
        debounced_in = 1'b1; p = cyc + 1; push(p, B_PRESS); push(p + 8, B_LONG);
        step(12);
        check_state(3'd2, "t2_long");
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE);
        step(6);
        check_state(3'd0, "t2_idle");

        // Double click
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(2);
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE);
        step(2);
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(2);
        check_state(3'd4, "t3_second");
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE | B_DOUBLE);
        step(6);
        check_state(3'd0, "t3_idle");

        // Second press exactly on the gap boundary still pairs up
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(2);
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE);
        step(4);
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(1);
        check_state(3'd4, "t4_gap_edge");
        step(1);
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE | B_DOUBLE);
        step(6);

        // One clock past the gap: short click, then a fresh press
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(2);
        debounced_in = 1'b0; r = cyc + 1; push(r, B_RELEASE); push(r + 4, B_SHORT);
        step(5);
        check_state(3'd0, "t4_expired");
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(1);
        check_state(3'd1, "t4_new_press");
        step(1);
        debounced_in = 1'b0; r = cyc + 1; push(r, B_RELEASE); push(r + 4, B_SHORT);
        step(8);

        // Held second press turns long: short and long together
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(2);
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE);
        step(2);
        debounced_in = 1'b1; p = cyc + 1; push(p, B_PRESS); push(p + 8, B_SHORT | B_LONG);
        step(10);
        check_state(3'd2, "second_long");
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE);
        step(6);

        // Slow tick: one tick every fourth clock
        tick_mode = 1;
        while ((cyc + 1) % 4 != 0) step(1);
        debounced_in = 1'b1; p = cyc + 1; push(p, B_PRESS); push(p + 32, B_LONG);
        step(31);
        check_state(3'd1, "t5_before_long");
        step(9);
        check_state(3'd2, "t5_long");
        debounced_in = 1'b0; push(cyc + 1, B_RELEASE);
        step(4);
        check_state(3'd0, "t5_idle");

        // No ticks: counter holds, no long press
        tick_mode = 2;
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(20);
        check_state(3'd1, "t5_hold");
        tick_mode = 0;
        debounced_in = 1'b0; r = cyc + 1; push(r, B_RELEASE); push(r + 4, B_SHORT);
        step(8);

        // Random short clicks
        repeat (4) begin
            h = $urandom_range(1, 6);
            debounced_in = 1'b1; push(cyc + 1, B_PRESS);
            step(h);
            debounced_in = 1'b0; r = cyc + 1; push(r, B_RELEASE); push(r + 4, B_SHORT);
            step(7);
        end

        // Reset mid-gesture discards it; held button re-presses after release
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(3);
        check_state(3'd1, "t6_pressed");
        rst = 1'b0;
        #1;
        check_state(3'd0, "t6_async_state");
        outs = {press_pulse, release_pulse, short_click, long_press, double_click, 1'b0};
        n_tests++;
        assert (outs === 6'b0) else begin
            n_fail++;
            $error("FAIL t6_async_outs: observed %b, expected 000000", outs);
        end
        step(2);
        rst = 1'b1; push(cyc + 1, B_PRESS);
        step(1);
        check_state(3'd1, "t6_repress");
        debounced_in = 1'b0; r = cyc + 1; push(r, B_RELEASE); push(r + 4, B_SHORT);
        step(8);

        // Reset with button up: nothing afterwards
        debounced_in = 1'b1; push(cyc + 1, B_PRESS);
        step(2);
        debounced_in = 1'b0;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(12);
        check_state(3'd0, "t6_quiet");

        // Final report
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL pending: observed %0d unmatched expected pulses, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
